maxpool_ctrl: RTL and testbench

//  Sequences 2x2/stride-2 max-pooling of a square feature map held in an external sync-read SRAM.

---
 rtl/maxpool_ctrl_pkg.sv | 19 +
 rtl/maxpool_ctrl_four_num_sorter.sv | 19 +
 rtl/maxpool_ctrl.sv | 140 ++++++++++++++
 tb/tb_maxpool_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_ctrl_pkg.sv
// Shared definitions for the max-pooling controller: sequencer states and
// default datapath constants.
package maxpool_ctrl_pkg;

    localparam int DEFAULT_DATA_WIDTH = 20;
    localparam int SRAM_RD_LATENCY    = 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_RD2  = 3'd3,
        ST_RD3  = 3'd4,
        ST_CAP  = 3'd5,
        ST_WR   = 3'd6,
        ST_DONE = 3'd7
    } state_t;

endpackage

// File: rtl/maxpool_ctrl_four_num_sorter.sv
// Signed maximum of four values, built as a two-level compare tree.
module four_num_sorter #(
    parameter int DATA_WIDTH = 20
) (
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    input  logic signed [DATA_WIDTH-1:0] c,
    input  logic signed [DATA_WIDTH-1:0] d,
    output logic signed [DATA_WIDTH-1:0] max_out
);

    logic signed [DATA_WIDTH-1:0] max_ab;
    logic signed [DATA_WIDTH-1:0] max_cd;

    assign max_ab  = (a > b) ? a : b;
    assign max_cd  = (c > d) ? c : d;
    assign max_out = (max_ab > max_cd) ? max_ab : max_cd;

endmodule

// File: rtl/maxpool_ctrl.sv
// 2x2 / stride-2 max-pool sequencer: reads four pixels per window from a
// sync-read SRAM, takes their signed max and writes it in raster order.
module maxpool_ctrl
    import maxpool_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int IMG_W      = 64,
    parameter int RD_AW      = 12,
    parameter int WR_AW      = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         rd_en,
    output logic [RD_AW-1:0]             rd_addr,
    input  logic signed [DATA_WIDTH-1:0] rd_data,
    output logic                         wr_en,
    output logic [WR_AW-1:0]             wr_addr,
    output logic signed [DATA_WIDTH-1:0] wr_data
);

    localparam int OW = IMG_W / 2;
    localparam int CW = (OW > 1) ? $clog2(OW) : 1;

    state_t state, state_nxt;
    logic [CW-1:0] orow, ocol;
    logic signed [DATA_WIDTH-1:0] cap_a, cap_b, cap_c, cap_d;
    logic row_off, col_off;
    logic last_col, last_win;
    logic [RD_AW-1:0] pix_row, pix_col;

    assign last_col = (ocol == CW'(OW - 1));
    assign last_win = last_col && (orow == CW'(OW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            orow <= '0;
            ocol <= '0;
        end else if (state == ST_IDLE && start) begin
            orow <= '0;
            ocol <= '0;
        end else if (state == ST_WR) begin
            if (last_col) begin
                ocol <= '0;
                orow <= last_win ? '0 : orow + 1'b1;
            end else begin
                ocol <= ocol + 1'b1;
            end
        end
    end

    // Read data lags its strobe by one cycle, so each pixel lands one state later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_a <= '0;
            cap_b <= '0;
            cap_c <= '0;
            cap_d <= '0;
        end else begin
            case (state)
                ST_RD1:  cap_a <= rd_data;
                ST_RD2:  cap_b <= rd_data;
                ST_RD3:  cap_c <= rd_data;
                ST_CAP:  cap_d <= rd_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        row_off   = 1'b0;
        col_off   = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = ST_RD0;
            end
            ST_RD0: begin
                rd_en     = 1'b1;
                state_nxt = ST_RD1;
            end
            ST_RD1: begin
                rd_en     = 1'b1;
                col_off   = 1'b1;
                state_nxt = ST_RD2;
            end
            ST_RD2: begin
                rd_en     = 1'b1;
                row_off   = 1'b1;
                state_nxt = ST_RD3;
            end
            ST_RD3: begin
                rd_en     = 1'b1;
                row_off   = 1'b1;
                col_off   = 1'b1;
                state_nxt = ST_CAP;
            end
            ST_CAP: state_nxt = ST_WR;
            ST_WR: begin
                wr_en     = 1'b1;
                wr_addr   = WR_AW'(WR_AW'(orow) * WR_AW'(OW) + WR_AW'(ocol));
                state_nxt = last_win ? ST_DONE : ST_RD0;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Pixel coordinates are 2*orow+row_off and 2*ocol+col_off.
        pix_row = RD_AW'({orow, row_off});
        pix_col = RD_AW'({ocol, col_off});
        if (rd_en) rd_addr = RD_AW'(pix_row * RD_AW'(IMG_W) + pix_col);
    end

    four_num_sorter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_sorter (
        .a      (cap_a),
        .b      (cap_b),
        .c      (cap_c),
        .d      (cap_d),
        .max_out(wr_data)
    );

endmodule

// File: tb/tb_maxpool_ctrl.sv
// Bench for maxpool_ctrl: a 4x4 instance for directed windows and reset abort,
// a 64x64 instance for a random map against a window-max reference.
module tb_maxpool_ctrl;

    localparam int DW = 20;

    typedef logic signed [31:0] word_t;
    typedef struct {
        word_t addr;
        word_t data;
        word_t cyc;
    } wr_rec_t;
    typedef struct {
        logic signed [DW-1:0] p0, p1, p2, p3;
        word_t exp_addr;
        word_t exp_data;
        word_t exp_cyc;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tcnt = 0;
    always @(posedge clk) tcnt <= tcnt + 1;

    int vecCount = 0;
    int missCount = 0;

    // 4x4 instance
    logic rst4_n, start4, busy4, done4, rd_en4, wr_en4;
    logic [3:0] rd_addr4;
    logic [1:0] wr_addr4;
    logic signed [DW-1:0] rd_data4, wr_data4;
    logic signed [DW-1:0] mem4 [16];

    maxpool_ctrl #(.DATA_WIDTH(DW), .IMG_W(4), .RD_AW(4), .WR_AW(2)) dut4 (
        .clk(clk), .rst_n(rst4_n), .start(start4), .busy(busy4), .done(done4),
        .rd_en(rd_en4), .rd_addr(rd_addr4), .rd_data(rd_data4),
        .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4)
    );

    // 64x64 instance
    logic rst64_n, start64, busy64, done64, rd_en64, wr_en64;
    logic [11:0] rd_addr64;
    logic [9:0] wr_addr64;
    logic signed [DW-1:0] rd_data64, wr_data64;
    logic signed [DW-1:0] mem64 [4096];

    maxpool_ctrl #(.DATA_WIDTH(DW), .IMG_W(64), .RD_AW(12), .WR_AW(10)) dut64 (
        .clk(clk), .rst_n(rst64_n), .start(start64), .busy(busy64), .done(done64),
        .rd_en(rd_en64), .rd_addr(rd_addr64), .rd_data(rd_data64),
        .wr_en(wr_en64), .wr_addr(wr_addr64), .wr_data(wr_data64)
    );

    always @(posedge clk) begin
        if (rd_en4)  rd_data4  <= mem4[rd_addr4];
        if (rd_en64) rd_data64 <= mem64[rd_addr64];
    end

    int s04 = 0, s064 = 0;
    int done4Cnt = 0, done64Cnt = 0;
    word_t done4Cyc = -1, done64Cyc = -1;
    wr_rec_t wq4[$];
    wr_rec_t wq64[$];

    // Record every write and done pulse with its cycle relative to the start cycle.
    always @(negedge clk) begin
        if (wr_en4)  wq4.push_back('{word_t'(wr_addr4), word_t'(wr_data4), word_t'(tcnt - s04)});
        if (wr_en64) wq64.push_back('{word_t'(wr_addr64), word_t'(wr_data64), word_t'(tcnt - s064)});
        if (done4) begin
            done4Cnt++;
            done4Cyc = word_t'(tcnt - s04);
        end
        if (done64) begin
            done64Cnt++;
            done64Cyc = word_t'(tcnt - s064);
        end
    end

    vec_t tbl [8];

    function automatic vec_t mk(int p0, int p1, int p2, int p3, int ea, int ed, int ec);
        vec_t v;
        v.p0 = DW'(p0);
        v.p1 = DW'(p1);
        v.p2 = DW'(p2);
        v.p3 = DW'(p3);
        v.exp_addr = ea;
        v.exp_data = ed;
        v.exp_cyc  = ec;
        return v;
    endfunction

    task automatic checkOutput(string name, word_t actual, word_t expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkQuiet4(string tag);
        checkOutput({tag, " busy4"},    word_t'(busy4),    0);
        checkOutput({tag, " done4"},    word_t'(done4),    0);
        checkOutput({tag, " rd_en4"},   word_t'(rd_en4),   0);
        checkOutput({tag, " wr_en4"},   word_t'(wr_en4),   0);
        checkOutput({tag, " rd_addr4"}, word_t'(rd_addr4), 0);
        checkOutput({tag, " wr_addr4"}, word_t'(wr_addr4), 0);
        checkOutput({tag, " wr_data4"}, word_t'(wr_data4), 0);
    endtask

    task automatic checkQuiet64(string tag);
        checkOutput({tag, " busy64"},    word_t'(busy64),    0);
        checkOutput({tag, " done64"},    word_t'(done64),    0);
        checkOutput({tag, " rd_en64"},   word_t'(rd_en64),   0);
        checkOutput({tag, " wr_en64"},   word_t'(wr_en64),   0);
        checkOutput({tag, " rd_addr64"}, word_t'(rd_addr64), 0);
        checkOutput({tag, " wr_addr64"}, word_t'(wr_addr64), 0);
    endtask

    // Place the four pixels of each table window at their raster addresses in the 4x4 map.
    task automatic applyStimulus(int run);
        for (int k = 0; k < 4; k++) begin
            int base;
            base = (2 * (k / 2)) * 4 + 2 * (k % 2);
            mem4[base]     = tbl[run * 4 + k].p0;
            mem4[base + 1] = tbl[run * 4 + k].p1;
            mem4[base + 4] = tbl[run * 4 + k].p2;
            mem4[base + 5] = tbl[run * 4 + k].p3;
        end
    endtask

    task automatic runTable4(int run);
        applyStimulus(run);
        wq4.delete();
        done4Cnt = 0;
        done4Cyc = -1;
        @(negedge clk);
        s04 = tcnt;
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (28) @(negedge clk);
        checkOutput($sformatf("run%0d write count", run), word_t'(wq4.size()), 4);
        for (int k = 0; k < 4; k++) begin
            wr_rec_t r;
            r = (k < wq4.size()) ? wq4[k] : '{-1, -1, -1};
            checkOutput($sformatf("run%0d win%0d addr", run, k), r.addr, tbl[run * 4 + k].exp_addr);
            checkOutput($sformatf("run%0d win%0d data", run, k), r.data, tbl[run * 4 + k].exp_data);
            checkOutput($sformatf("run%0d win%0d cycle", run, k), r.cyc, tbl[run * 4 + k].exp_cyc);
        end
        checkOutput($sformatf("run%0d done count", run), word_t'(done4Cnt), 1);
        checkOutput($sformatf("run%0d done cycle", run), done4Cyc, 25);
        checkOutput($sformatf("run%0d busy after", run), word_t'(busy4), 0);
    endtask

    // Random 64x64 run; optionally pulses start at cycles 3, 50 and the done cycle.
    task automatic run64(bit pulses);
        word_t golden[$];
        logic busyAtDone, busyAfter;
        for (int i = 0; i < 4096; i++) mem64[i] = DW'($urandom);
        for (int orow = 0; orow < 32; orow++) begin
            for (int ocol = 0; ocol < 32; ocol++) begin
                word_t m;
                m = word_t'(mem64[(2 * orow) * 64 + 2 * ocol]);
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++)
                        if (word_t'(mem64[(2 * orow + dr) * 64 + 2 * ocol + dc]) > m)
                            m = word_t'(mem64[(2 * orow + dr) * 64 + 2 * ocol + dc]);
                golden.push_back(m);
            end
        end
        wq64.delete();
        done64Cnt = 0;
        done64Cyc = -1;
        busyAtDone = 1'b0;
        busyAfter = 1'b1;
        @(negedge clk);
        s064 = tcnt;
        start64 = 1'b1;
        for (int i = 1; i <= 6160; i++) begin
            @(negedge clk);
            start64 = pulses && (i == 3 || i == 50 || i == 6145);
            if (i == 6145) busyAtDone = busy64;
            if (i == 6146) busyAfter = busy64;
        end
        start64 = 1'b0;
        checkOutput("map64 write count", word_t'(wq64.size()), 1024);
        for (int k = 0; k < 1024; k++) begin
            wr_rec_t r;
            r = (k < wq64.size()) ? wq64[k] : '{-1, -1, -1};
            checkOutput($sformatf("map64 win%0d addr", k), r.addr, word_t'(k));
            checkOutput($sformatf("map64 win%0d data", k), r.data, golden[k]);
            checkOutput($sformatf("map64 win%0d cycle", k), r.cyc, word_t'(6 * (k + 1)));
        end
        checkOutput("map64 done count", word_t'(done64Cnt), 1);
        checkOutput("map64 done cycle", done64Cyc, 6145);
        checkOutput("map64 busy at done", word_t'(busyAtDone), 1);
        checkOutput("map64 busy after done", word_t'(busyAfter), 0);
    endtask

    initial begin
        tbl[0] = mk(0, 1, 4, 5, 0, 5, 6);
        tbl[1] = mk(2, 3, 6, 7, 1, 7, 12);
        tbl[2] = mk(8, 9, 12, 13, 2, 13, 18);
        tbl[3] = mk(10, 11, 14, 15, 3, 15, 24);
        tbl[4] = mk(-5, -3, -7, -1, 0, -1, 6);
        tbl[5] = mk(-524288, 0, 0, -524288, 1, 0, 12);
        tbl[6] = mk(100, -100, 99, -2, 2, 100, 18);
        tbl[7] = mk(-8, -8, -8, -8, 3, -8, 24);

        start4 = 1'b0;
        start64 = 1'b0;
        rst4_n = 1'b1;
        rst64_n = 1'b1;
        #1;
        rst4_n = 1'b0;
        rst64_n = 1'b0;

        $display("[TB] reset hold with random start");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start4 = 1'($urandom_range(0, 1));
            start64 = 1'($urandom_range(0, 1));
            #1;
            checkQuiet4($sformatf("reset%0d", i));
            checkQuiet64($sformatf("reset%0d", i));
        end
        @(negedge clk);
        start4 = 1'b0;
        start64 = 1'b0;
        rst4_n = 1'b1;
        rst64_n = 1'b1;
        repeat (2) @(negedge clk);
        checkQuiet4("post-reset idle");

        $display("[TB] 4x4 directed windows");
        for (int run = 0; run < 2; run++) runTable4(run);

        $display("[TB] 4x4 reset abort mid window 2");
        applyStimulus(0);
        wq4.delete();
        done4Cnt = 0;
        @(negedge clk);
        s04 = tcnt;
        start4 = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            start4 = 1'b0;
        end
        rst4_n = 1'b0;
        #1;
        checkQuiet4("abort");
        repeat (12) @(negedge clk);
        checkQuiet4("abort hold");
        checkOutput("abort write count", word_t'(wq4.size()), 2);
        checkOutput("abort done count", word_t'(done4Cnt), 0);
        rst4_n = 1'b1;
        repeat (2) @(negedge clk);
        runTable4(0);

        $display("[TB] 64x64 random map");
        run64(1'b0);
        $display("[TB] 64x64 random map with ignored start pulses");
        run64(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
